// File: rtl/lif_euler_step.sv
`default_nettype none
// ============================================================================
// Module   : lif_euler_step
// Purpose  : One forward-Euler update of a leaky integrate-and-fire membrane
//            voltage per accepted current sample. All values are Q16.16
//            sign-magnitude words (bit N-1 sign, bits N-2:0 magnitude).
//            Each update computes
//              v_next = v + DT_OVER_TAU*(V_REST - v) + GAIN*i
//            and then applies the threshold and refractory rules.
// Ports    : clk, rst_n       - clock, asynchronous active-low reset
//            in_valid/in_ready - input handshake, i_in = current sample
//            out_valid/out_ready - output handshake
//            v_out            - updated membrane voltage
//            spike            - this update crossed threshold
//            refractory       - refractory counter is nonzero
// Revision : 1.0 - initial release
// ============================================================================
module lif_euler_step #(
  parameter int           N             = 32,
  parameter int           Q             = 16,
  parameter logic [N-1:0] V_REST        = 32'h80410000,
  parameter logic [N-1:0] V_TH          = 32'h80320000,
  parameter logic [N-1:0] V_RESET       = 32'h80460000,
  parameter logic [N-1:0] DT_OVER_TAU   = 32'h0000199A,
  parameter logic [N-1:0] GAIN          = 32'h00010000,
  parameter int           REFRAC_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] i_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] v_out,
  output logic         spike,
  output logic         refractory
);

  localparam int c_mag_w  = N - 1;
  localparam int c_cw_raw = $clog2(REFRAC_CYCLES + 1);
  localparam int c_cnt_w  = (c_cw_raw < 1) ? 1 : c_cw_raw;
  localparam logic [c_cnt_w-1:0] c_refrac_load = c_cnt_w'(REFRAC_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_one     = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_SUM  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  // Build a word from sign and magnitude; a zero magnitude always gets sign 0.
  function automatic logic [N-1:0] sm_norm(input logic s, input logic [c_mag_w-1:0] m);
    return {s & (|m), m};
  endfunction

  // Sign-magnitude fixed-point multiply, truncated toward zero, saturating.
  function automatic logic [N-1:0] sm_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*c_mag_w-1:0] p;
    logic [c_mag_w-1:0]   m;
    p = {{c_mag_w{1'b0}}, a[c_mag_w-1:0]} * {{c_mag_w{1'b0}}, b[c_mag_w-1:0]};
    // Any bit above the kept window means the scaled result does not fit.
    if (|p[2*c_mag_w-1:c_mag_w+Q]) m = '1;
    else                           m = p[c_mag_w-1+Q:Q];
    return sm_norm(a[N-1] ^ b[N-1], m);
  endfunction

  // Sign-magnitude add; like-sign overflow saturates with the operand sign.
  function automatic logic [N-1:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [c_mag_w:0]   s;
    logic [c_mag_w-1:0] m;
    logic               sg;
    s = '0;
    if (a[N-1] == b[N-1]) begin
      s  = {1'b0, a[c_mag_w-1:0]} + {1'b0, b[c_mag_w-1:0]};
      m  = s[c_mag_w] ? '1 : s[c_mag_w-1:0];
      sg = a[N-1];
    end else if (a[c_mag_w-1:0] >= b[c_mag_w-1:0]) begin
      m  = a[c_mag_w-1:0] - b[c_mag_w-1:0];
      sg = a[N-1];
    end else begin
      m  = b[c_mag_w-1:0] - a[c_mag_w-1:0];
      sg = b[N-1];
    end
    return sm_norm(sg, m);
  endfunction

  function automatic logic [N-1:0] sm_sub(input logic [N-1:0] a, input logic [N-1:0] b);
    return sm_add(a, {~b[N-1], b[c_mag_w-1:0]});
  endfunction

  // a >= b in sign-magnitude order; -0 is treated as +0.
  function automatic logic sm_ge(input logic [N-1:0] a, input logic [N-1:0] b);
    logic a_neg, b_neg;
    a_neg = a[N-1] & (|a[c_mag_w-1:0]);
    b_neg = b[N-1] & (|b[c_mag_w-1:0]);
    if (!a_neg && b_neg) return 1'b1;
    if (a_neg && !b_neg) return 1'b0;
    if (!a_neg)          return a[c_mag_w-1:0] >= b[c_mag_w-1:0];
    return a[c_mag_w-1:0] <= b[c_mag_w-1:0];
  endfunction

  state_t               r_state;
  state_t               w_state_next;
  logic [N-1:0]         r_i;
  logic [N-1:0]         r_leak;
  logic [N-1:0]         r_drive;
  logic [N-1:0]         r_v;
  logic [N-1:0]         r_v_out;
  logic                 r_spike;
  logic                 r_out_valid;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [N-1:0]         w_leak;
  logic [N-1:0]         w_drive;
  logic [N-1:0]         w_v_next;
  logic                 w_cross;

  assign w_leak   = sm_mul(DT_OVER_TAU, sm_sub(V_REST, r_v));
  assign w_drive  = sm_mul(GAIN, r_i);
  assign w_v_next = sm_add(sm_add(r_v, r_leak), r_drive);
  assign w_cross  = sm_ge(w_v_next, V_TH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = S_MUL;
      end
      S_MUL:   w_state_next = S_SUM;
      S_SUM:   w_state_next = S_OUT;
      S_OUT:   if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i         <= '0;
      r_leak      <= '0;
      r_drive     <= '0;
      r_v         <= V_REST;
      r_v_out     <= V_REST;
      r_spike     <= 1'b0;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) r_i <= i_in;
        S_MUL: begin
          r_leak  <= w_leak;
          r_drive <= w_drive;
        end
        S_SUM: begin
          r_out_valid <= 1'b1;
          if (r_cnt != '0) begin
            // Refractory: clamp without evaluating the threshold.
            r_v     <= V_RESET;
            r_v_out <= V_RESET;
            r_spike <= 1'b0;
            r_cnt   <= r_cnt - c_cnt_one;
          end else if (w_cross) begin
            r_v     <= V_RESET;
            r_v_out <= V_RESET;
            r_spike <= 1'b1;
            r_cnt   <= c_refrac_load;
          end else begin
            r_v     <= w_v_next;
            r_v_out <= w_v_next;
            r_spike <= 1'b0;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_spike     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign v_out      = r_v_out;
  assign spike      = r_spike;
  assign refractory = |r_cnt;

endmodule
`default_nettype wire
